// File: rtl/blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// blackjack_round_ctrl
//
// Sequences one blackjack round between two players, Slave and Master.
// It requests cards from a deck source, deals the opening hand (Slave,
// Master, Slave, Master), then runs the Slave's hit/stand turn followed by
// the Master's. It keeps both running totals and the sticky finish flags
// that the result-display logic reads directly.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             begin a round (honoured only in IDLE or DONE)
//   hitSlave          Slave asks for a card (S_TURN only)
//   standSlave        Slave ends its turn (S_TURN only)
//   hitMaster         Master asks for a card (M_TURN only)
//   standMaster       Master ends its turn (M_TURN only)
//   cardValid         deck source presents a card on cardValue
//   cardValue[3:0]    rank code 0..15 (0 = discard, 11..15 weigh 10)
//   cardReq           controller wants a card (DEAL, S_DRAW, M_DRAW)
//   turnMaster        0 = Slave to act / be dealt, 1 = Master
//   totalValueSlave   Slave running total
//   totalValueMaster  Master running total
//   finishSlave       Slave turn closed (sticky until start/reset)
//   finishMaster      Master turn closed (sticky until start/reset)
//   roundDone         high while in DONE
//   stateDbg[2:0]     current FSM state, for observation only
//
// Card handshake: cardReq acts as ready and cardValid as valid. A card
// transfers on every rising edge where both are high; the total it feeds
// is visible the cycle after. cardReq is held until a card is taken, and
// cardValid while cardReq is low has no effect. A rank-0 card completes the
// transfer but is thrown away, so cardReq stays high for a replacement.
// -----------------------------------------------------------------------------
module blackjack_round_ctrl #(
   parameter int TURN_TIMEOUT = 255,
   parameter int BUST_LIMIT   = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hitSlave,
   input  logic       standSlave,
   input  logic       hitMaster,
   input  logic       standMaster,
   input  logic       cardValid,
   input  logic [3:0] cardValue,
   output logic       cardReq,
   output logic       turnMaster,
   output logic [4:0] totalValueSlave,
   output logic [4:0] totalValueMaster,
   output logic       finishSlave,
   output logic       finishMaster,
   output logic       roundDone,
   output logic [2:0] stateDbg
);

   localparam int            CW          = $clog2(TURN_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TURN_TIMEOUT);
   localparam logic [4:0]    LIMIT       = 5'(BUST_LIMIT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DEAL   = 3'd1,
      S_TURN = 3'd2,
      S_DRAW = 3'd3,
      M_TURN = 3'd4,
      M_DRAW = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t        state;
   state_t        nextState;
   logic [1:0]    dealIdx;
   logic [CW-1:0] turnTimer;

   logic [4:0] cardWeight;
   logic       cardTaken;
   logic [4:0] slaveSum;
   logic [4:0] masterSum;
   logic       timedOut;

   logic addSlave;
   logic addMaster;
   logic setFinishSlave;
   logic setFinishMaster;
   logic clearRound;
   logic dealAdvance;

   assign stateDbg = state;

   // Rank to weight; rank 0 weighs nothing and is never added.
   always_comb begin
      cardWeight = 5'd0;
      if (cardValue > 4'd10)
         cardWeight = 5'd10;
      else
         cardWeight = {1'b0, cardValue};
   end

   // A card that actually counts: transferred and not a discard.
   assign cardTaken = cardReq && cardValid && (cardValue != 4'd0);
   // Draws only happen at totals <= 20, so 5 bits always hold the sum.
   assign slaveSum  = totalValueSlave + cardWeight;
   assign masterSum = totalValueMaster + cardWeight;
   assign timedOut  = (turnTimer == TIMEOUT_VAL);

   // Next-state and control decode.
   always_comb begin
      nextState       = state;
      cardReq         = 1'b0;
      turnMaster      = 1'b0;
      roundDone       = 1'b0;
      addSlave        = 1'b0;
      addMaster       = 1'b0;
      setFinishSlave  = 1'b0;
      setFinishMaster = 1'b0;
      clearRound      = 1'b0;
      dealAdvance     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               clearRound = 1'b1;
               nextState  = DEAL;
            end
         end

         DEAL: begin
            cardReq    = 1'b1;
            turnMaster = dealIdx[0];
            if (cardTaken) begin
               dealAdvance = 1'b1;
               if (dealIdx[0])
                  addMaster = 1'b1;
               else
                  addSlave = 1'b1;
               if (dealIdx == 2'd3)
                  nextState = S_TURN;
            end
         end

         S_TURN: begin
            // Stand (explicit, timeout or exact limit) beats hit.
            if (standSlave || timedOut || (totalValueSlave == LIMIT)) begin
               setFinishSlave = 1'b1;
               nextState      = M_TURN;
            end else if (hitSlave) begin
               nextState = S_DRAW;
            end
         end

         S_DRAW: begin
            cardReq = 1'b1;
            if (cardTaken) begin
               addSlave = 1'b1;
               if (slaveSum > LIMIT) begin
                  // Slave bust ends the round; the Master does not play.
                  setFinishSlave  = 1'b1;
                  setFinishMaster = 1'b1;
                  nextState       = DONE;
               end else if (slaveSum == LIMIT) begin
                  setFinishSlave = 1'b1;
                  nextState      = M_TURN;
               end else begin
                  nextState = S_TURN;
               end
            end
         end

         M_TURN: begin
            turnMaster = 1'b1;
            if (standMaster || timedOut || (totalValueMaster == LIMIT)) begin
               setFinishMaster = 1'b1;
               nextState       = DONE;
            end else if (hitMaster) begin
               nextState = M_DRAW;
            end
         end

         M_DRAW: begin
            cardReq    = 1'b1;
            turnMaster = 1'b1;
            if (cardTaken) begin
               addMaster = 1'b1;
               if (masterSum >= LIMIT) begin
                  setFinishMaster = 1'b1;
                  nextState       = DONE;
               end else begin
                  nextState = M_TURN;
               end
            end
         end

         DONE: begin
            roundDone = 1'b1;
            if (start) begin
               clearRound = 1'b1;
               nextState  = DEAL;
            end
         end

         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State, totals, flags, deal index and turn timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         dealIdx          <= 2'd0;
         turnTimer        <= '0;
         totalValueSlave  <= 5'd0;
         totalValueMaster <= 5'd0;
         finishSlave      <= 1'b0;
         finishMaster     <= 1'b0;
      end else begin
         state <= nextState;

         if (clearRound) begin
            totalValueSlave  <= 5'd0;
            totalValueMaster <= 5'd0;
            finishSlave      <= 1'b0;
            finishMaster     <= 1'b0;
            dealIdx          <= 2'd0;
         end else begin
            if (addSlave)
               totalValueSlave <= slaveSum;
            if (addMaster)
               totalValueMaster <= masterSum;
            if (setFinishSlave)
               finishSlave <= 1'b1;
            if (setFinishMaster)
               finishMaster <= 1'b1;
            if (dealAdvance)
               dealIdx <= dealIdx + 2'd1;
         end

         // The timer restarts on every state change, so each entry into a
         // turn state (including the return from a draw) starts from zero.
         // A turn state always leaves when the timer hits TURN_TIMEOUT, so
         // it never wraps.
         if (nextState != state)
            turnTimer <= '0;
         else if ((state == S_TURN) || (state == M_TURN))
            turnTimer <= turnTimer + CW'(1);
         else
            turnTimer <= '0;
      end
   end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blackjack_round_ctrl
//
// Directed bench for blackjack_round_ctrl built with TURN_TIMEOUT = 8.
// A table of {inputs, expected outputs} records covers the main rounds;
// hand-written sequences cover reset, the turn timeout and an asynchronous
// reset in the middle of the deal.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_blackjack_round_ctrl;

   localparam int TURN_TIMEOUT = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DEAL   = 3'd1;
   localparam logic [2:0] ST_S_TURN = 3'd2;
   localparam logic [2:0] ST_S_DRAW = 3'd3;
   localparam logic [2:0] ST_M_TURN = 3'd4;
   localparam logic [2:0] ST_M_DRAW = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   // Input codes: {start, hitSlave, standSlave, hitMaster, standMaster, cardValid}
   localparam logic [5:0] I_NONE  = 6'b000000;
   localparam logic [5:0] I_START = 6'b100000;
   localparam logic [5:0] I_HS    = 6'b010000;
   localparam logic [5:0] I_SS    = 6'b001000;
   localparam logic [5:0] I_HM    = 6'b000100;
   localparam logic [5:0] I_SM    = 6'b000010;
   localparam logic [5:0] I_CV    = 6'b000001;

   typedef struct {
      string       name;
      logic [5:0]  ins;
      logic [3:0]  cval;
      logic [17:0] exp;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;
   logic       start;
   logic       hitSlave;
   logic       standSlave;
   logic       hitMaster;
   logic       standMaster;
   logic       cardValid;
   logic [3:0] cardValue;
   logic       cardReq;
   logic       turnMaster;
   logic [4:0] totalValueSlave;
   logic [4:0] totalValueMaster;
   logic       finishSlave;
   logic       finishMaster;
   logic       roundDone;
   logic [2:0] stateDbg;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   blackjack_round_ctrl #(
      .TURN_TIMEOUT(TURN_TIMEOUT),
      .BUST_LIMIT  (21)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .hitSlave        (hitSlave),
      .standSlave      (standSlave),
      .hitMaster       (hitMaster),
      .standMaster     (standMaster),
      .cardValid       (cardValid),
      .cardValue       (cardValue),
      .cardReq         (cardReq),
      .turnMaster      (turnMaster),
      .totalValueSlave (totalValueSlave),
      .totalValueMaster(totalValueMaster),
      .finishSlave     (finishSlave),
      .finishMaster    (finishMaster),
      .roundDone       (roundDone),
      .stateDbg        (stateDbg)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [17:0] exp_q[$];
   vec_t        vecs[$];

   function automatic logic [17:0] pk(int req, int turn, int s, int m,
                                      int fs, int fm, int done, logic [2:0] st);
      return {1'(req), 1'(turn), 5'(s), 5'(m), 1'(fs), 1'(fm), 1'(done), st};
   endfunction

   function automatic logic [17:0] dut_word();
      return {cardReq, turnMaster, totalValueSlave, totalValueMaster,
              finishSlave, finishMaster, roundDone, stateDbg};
   endfunction

   function automatic string fmt(logic [17:0] w);
      return $sformatf("req=%0b turn=%0b S=%0d M=%0d fs=%0b fm=%0b done=%0b st=%0d",
                       w[17], w[16], w[15:11], w[10:6], w[5], w[4], w[3], w[2:0]);
   endfunction

   function automatic vec_t mk(string name, logic [5:0] ins, int cval, logic [17:0] exp);
      vec_t v;
      v.name = name;
      v.ins  = ins;
      v.cval = 4'(cval);
      v.exp  = exp;
      return v;
   endfunction

   task automatic check_word(input string name, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic [5:0] ins, input logic [3:0] cval);
      {start, hitSlave, standSlave, hitMaster, standMaster, cardValid} = ins;
      cardValue = cval;
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v.ins, v.cval);
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      check_word(v.name, dut_word(), exp_q.pop_front());
   endtask

   // Deals 2,3,4,5 from a fresh start: S=6, M=8, ends in S_TURN.
   task automatic deal_small(input string tag);
      apply(mk({tag, ".start"}, I_START, 0, pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      apply(mk({tag, ".c2"}, I_CV, 2, pk(1, 1, 2, 0, 0, 0, 0, ST_DEAL)));
      apply(mk({tag, ".c3"}, I_CV, 3, pk(1, 0, 2, 3, 0, 0, 0, ST_DEAL)));
      apply(mk({tag, ".c4"}, I_CV, 4, pk(1, 1, 6, 3, 0, 0, 0, ST_DEAL)));
      apply(mk({tag, ".c5"}, I_CV, 5, pk(0, 0, 6, 8, 0, 0, 0, ST_S_TURN)));
   endtask

   function automatic void build_table();
      // Basic round
      vecs.push_back(mk("b.start",  I_START, 0,  pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("b.c10",    I_CV,    10, pk(1, 1, 10, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("b.c7",     I_CV,    7,  pk(1, 0, 10, 7, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("b.c5",     I_CV,    5,  pk(1, 1, 15, 7, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("b.c9",     I_CV,    9,  pk(0, 0, 15, 16, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("b.hmIgn",  I_HM|I_SM, 0, pk(0, 0, 15, 16, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("b.standS", I_SS,    0,  pk(0, 1, 15, 16, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("b.sIgn",   I_HS|I_SS, 0, pk(0, 1, 15, 16, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("b.standM", I_SM,    0,  pk(0, 0, 15, 16, 1, 1, 1, ST_DONE)));
      vecs.push_back(mk("b.cvIgn",  I_CV,    9,  pk(0, 0, 15, 16, 1, 1, 1, ST_DONE)));
      // Slave bust; start during DEAL ignored
      vecs.push_back(mk("s.start",  I_START, 0,  pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("s.c10",    I_START|I_CV, 10, pk(1, 1, 10, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("s.c2",     I_CV,    2,  pk(1, 0, 10, 2, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("s.c6",     I_CV,    6,  pk(1, 1, 16, 2, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("s.c3",     I_CV,    3,  pk(0, 0, 16, 5, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("s.hit",    I_HS,    0,  pk(1, 0, 16, 5, 0, 0, 0, ST_S_DRAW)));
      vecs.push_back(mk("s.c13",    I_CV,    13, pk(0, 0, 26, 5, 1, 1, 1, ST_DONE)));
      vecs.push_back(mk("s.mIgn",   I_HM|I_SM, 0, pk(0, 0, 26, 5, 1, 1, 1, ST_DONE)));
      // Auto-stand at 21, discard card, Master bust
      vecs.push_back(mk("a.start",  I_START, 0,  pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("a.c10",    I_CV,    10, pk(1, 1, 10, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("a.c4",     I_CV,    4,  pk(1, 0, 10, 4, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("a.c1",     I_CV,    1,  pk(1, 1, 11, 4, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("a.c4b",    I_CV,    4,  pk(0, 0, 11, 8, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("a.hit",    I_HS,    0,  pk(1, 0, 11, 8, 0, 0, 0, ST_S_DRAW)));
      vecs.push_back(mk("a.c10s",   I_CV,    10, pk(0, 1, 21, 8, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("a.hitM",   I_HM,    0,  pk(1, 1, 21, 8, 1, 0, 0, ST_M_DRAW)));
      vecs.push_back(mk("a.c0",     I_CV,    0,  pk(1, 1, 21, 8, 1, 0, 0, ST_M_DRAW)));
      vecs.push_back(mk("a.c12",    I_CV,    12, pk(0, 1, 21, 18, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("a.hitM2",  I_HM,    0,  pk(1, 1, 21, 18, 1, 0, 0, ST_M_DRAW)));
      vecs.push_back(mk("a.c10m",   I_CV,    10, pk(0, 0, 21, 28, 1, 1, 1, ST_DONE)));
      // Stalled source, then Master reaches exactly 21
      vecs.push_back(mk("t.start",  I_START, 0,  pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("t.c2",     I_CV,    2,  pk(1, 1, 2, 0, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("t.c3",     I_CV,    3,  pk(1, 0, 2, 3, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("t.c4",     I_CV,    4,  pk(1, 1, 6, 3, 0, 0, 0, ST_DEAL)));
      vecs.push_back(mk("t.c5",     I_CV,    5,  pk(0, 0, 6, 8, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("t.hit",    I_HS,    0,  pk(1, 0, 6, 8, 0, 0, 0, ST_S_DRAW)));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk($sformatf("t.stall%0d", i), (i % 2 == 1) ? I_START : I_NONE,
                           i % 16, pk(1, 0, 6, 8, 0, 0, 0, ST_S_DRAW)));
      vecs.push_back(mk("t.c5s",    I_CV,    5,  pk(0, 0, 11, 8, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("t.cvNoReq", I_CV,   9,  pk(0, 0, 11, 8, 0, 0, 0, ST_S_TURN)));
      vecs.push_back(mk("t.hit2",   I_HS,    0,  pk(1, 0, 11, 8, 0, 0, 0, ST_S_DRAW)));
      vecs.push_back(mk("t.c10",    I_CV,    10, pk(0, 1, 21, 8, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("t.hitM",   I_HM,    0,  pk(1, 1, 21, 8, 1, 0, 0, ST_M_DRAW)));
      vecs.push_back(mk("t.c13",    I_CV,    13, pk(0, 1, 21, 18, 1, 0, 0, ST_M_TURN)));
      vecs.push_back(mk("t.hitM2",  I_HM,    0,  pk(1, 1, 21, 18, 1, 0, 0, ST_M_DRAW)));
      vecs.push_back(mk("t.c3",     I_CV,    3,  pk(0, 0, 21, 21, 1, 1, 1, ST_DONE)));
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int cycles;

      rst = 1'b1;
      drive(I_NONE, 4'd0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_word("reset", dut_word(), pk(0, 0, 0, 0, 0, 0, 0, ST_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // Table-driven rounds
      build_table();
      foreach (vecs[i])
         apply(vecs[i]);

      // Turn timeout: finishSlave must rise exactly 9 edges after S_TURN entry
      deal_small("to");
      cycles = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(I_NONE, 4'd0);
         @(posedge clk);
         #1;
         cycles++;
         if (finishSlave)
            break;
      end
      check_int("to.cycles", finishSlave ? cycles : -1, TURN_TIMEOUT + 1);
      check_word("to.mturn", dut_word(), pk(0, 1, 6, 8, 1, 0, 0, ST_M_TURN));
      // Hit and stand together in M_TURN: stand wins, no card requested
      apply(mk("to.hitStand", I_HM|I_SM, 0, pk(0, 0, 6, 8, 1, 1, 1, ST_DONE)));

      // Asynchronous reset in the middle of the deal
      apply(mk("ar.start", I_START, 0,  pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      apply(mk("ar.c10",   I_CV,    10, pk(1, 1, 10, 0, 0, 0, 0, ST_DEAL)));
      @(negedge clk);
      drive(I_CV, 4'd7);
      #2;
      rst = 1'b1;
      #1;
      check_word("ar.async", dut_word(), pk(0, 0, 0, 0, 0, 0, 0, ST_IDLE));
      @(negedge clk);
      drive(I_NONE, 4'd0);
      check_word("ar.held", dut_word(), pk(0, 0, 0, 0, 0, 0, 0, ST_IDLE));
      rst = 1'b0;
      apply(mk("ar.restart", I_START, 0, pk(1, 0, 0, 0, 0, 0, 0, ST_DEAL)));
      apply(mk("ar.idx0",    I_CV,    3, pk(1, 1, 3, 0, 0, 0, 0, ST_DEAL)));

      // ---------------- report ----------------
      @(negedge clk);
      drive(I_NONE, 4'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
